// File: rtl/imm_decode_stage.sv
// Registered immediate decoder between fetch and execute.
// A two-entry buffer (output register + skid register) keeps in_ready_o registered.
module imm_decode_stage #(
  parameter int XLEN       = 32,
  parameter bit SYSTEM_IMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            illegal_o
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
  } entry_t;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  entry_t      dec, out_q, skid_q;
  logic        out_valid, skid_valid;
  logic        accept, drain;
  logic [11:0] i_imm, s_imm;
  logic [12:0] b_imm;
  logic [31:0] u_imm;
  logic [20:0] j_imm;

  assign i_imm = instr_i[31:20];
  assign s_imm = {instr_i[31:25], instr_i[11:7]};
  assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.instr   = instr_i;
    dec.pc      = pc_i;
    if (instr_i[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (instr_i[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec.typ = T_I; dec.imm = XLEN'($signed(i_imm));
        end
        7'b0100011: begin dec.typ = T_S; dec.imm = XLEN'($signed(s_imm)); end
        7'b1100011: begin dec.typ = T_B; dec.imm = XLEN'($signed(b_imm)); end
        7'b0110111, 7'b0010111: begin
          dec.typ = T_U; dec.imm = XLEN'($signed(u_imm));
        end
        7'b1101111: begin dec.typ = T_J; dec.imm = XLEN'($signed(j_imm)); end
        7'b0110011, 7'b0001111: dec.typ = T_NONE;
        7'b1110011: begin
          if (SYSTEM_IMM) begin
            dec.typ = T_I; dec.imm = XLEN'($signed(i_imm));
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign in_ready_o = ~skid_valid;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign drain      = out_valid & out_ready_i;

  // Skid only fills while the output register is stalled, so it always refills first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q      <= dec;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid_o = out_valid;
  assign instr_o     = out_q.instr;
  assign pc_o        = out_q.pc;
  assign imm_o       = out_q.imm;
  assign imm_type_o  = out_q.typ;
  assign illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: 32- and 64-bit instances share stimulus; expectations queued on accept.
module tb_imm_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] ins32, pc32, imm32;
  logic [2:0]  typ32;
  logic        rdy64, vld64, ill64;
  logic [31:0] ins64;
  logic [63:0] pc64, imm64;
  logic [2:0]  typ64;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) d32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .instr_i(instr), .pc_i(pc[31:0]),
    .out_valid_o(vld32), .out_ready_i(out_ready), .instr_o(ins32), .pc_o(pc32),
    .imm_o(imm32), .imm_type_o(typ32), .illegal_o(ill32));

  imm_decode_stage #(.XLEN(64)) d64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .instr_i(instr), .pc_i(pc),
    .out_valid_o(vld64), .out_ready_i(out_ready), .instr_o(ins64), .pc_o(pc64),
    .imm_o(imm64), .imm_type_o(typ64), .illegal_o(ill64));

  // Reference decode: place the immediate at the top of a signed word and shift down.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    logic signed [63:0] t;
    e.instr = i; e.pc = p; e.imm = 64'd0; e.typ = 3'd0; e.ill = 1'b0;
    t = 64'sd0;
    if (i[1:0] != 2'b11) e.ill = 1'b1;
    else case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin t = {i[31:20], 52'b0}; e.imm = t >>> 52; e.typ = 3'd1; end
      7'h23: begin t = {i[31:25], i[11:7], 52'b0}; e.imm = t >>> 52; e.typ = 3'd2; end
      7'h63: begin t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}; e.imm = t >>> 51; e.typ = 3'd3; end
      7'h37, 7'h17: begin t = {i[31:12], 44'b0}; e.imm = t >>> 32; e.typ = 3'd4; end
      7'h6f: begin t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}; e.imm = t >>> 43; e.typ = 3'd5; end
      7'h33, 7'h0f: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] i, input logic [63:0] p,
                              input logic [63:0] imm, input logic [2:0] typ, input logic ill);
    exp_t e;
    e.instr = i; e.pc = p; e.imm = imm; e.typ = typ; e.ill = ill;
    return e;
  endfunction

  // Each drain seen by the consumer pops one expectation and checks both instances.
  always @(negedge clk) begin
    if (vld32 === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc=%h instr=%h, required no output", pc32, ins32);
      end else begin
        e = q.pop_front();
        if ({ins32, pc32, imm32, typ32, ill32} !== {e.instr, e.pc[31:0], e.imm[31:0], e.typ, e.ill}) begin
          errors++;
          $display("FAIL out32: got instr=%h pc=%h imm=%h typ=%0d ill=%b, required instr=%h pc=%h imm=%h typ=%0d ill=%b",
                   ins32, pc32, imm32, typ32, ill32, e.instr, e.pc[31:0], e.imm[31:0], e.typ, e.ill);
        end
        checks++;
        if (vld64 !== 1'b1 || {ins64, pc64, imm64, typ64, ill64} !== {e.instr, e.pc, e.imm, e.typ, e.ill}) begin
          errors++;
          $display("FAIL out64: got vld=%b instr=%h pc=%h imm=%h typ=%0d ill=%b, required instr=%h pc=%h imm=%h typ=%0d ill=%b",
                   vld64, ins64, pc64, imm64, typ64, ill64, e.instr, e.pc, e.imm, e.typ, e.ill);
        end
      end
    end
  end

  // Hold one instruction on the input until accepted; returns 1 ns after the accepting edge.
  task automatic drive(input logic [31:0] i, input logic [63:0] p, input exp_t e);
    in_valid = 1'b1; instr = i; pc = p;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rdy32 === 1'b1 && flush === 1'b0) begin
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: pc=%h never accepted, required acceptance within 60 cycles", p);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 60 && (q.size() != 0 || vld32 === 1'b1); k++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0 || vld32 !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d out_valid=%b, required 0 and 0", name, q.size(), vld32);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_handshake: got vld=%b%b rdy=%b%b, required vld=00 rdy=11", vld32, vld64, rdy32, rdy64);
    end
    checks++;
    if ({ins32, pc32, imm32, typ32, ill32, ins64, pc64, imm64, typ64, ill64} !== '0) begin
      errors++;
      $display("FAIL reset_data: got imm32=%h imm64=%h pc64=%h typ=%0d ill=%b, required all zero",
               imm32, imm64, pc64, typ64, ill64);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    drive(32'hFFF00093, 64'h0000_0000_0000_1000, mk(32'hFFF00093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0));
    drive(32'hFE112E23, 64'h0000_0000_0000_1004, mk(32'hFE112E23, 64'h1004, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0));
    drive(32'hFE000CE3, 64'h0000_0000_0000_1008, mk(32'hFE000CE3, 64'h1008, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0));
    drive(32'h800000B7, 64'h0000_0000_0000_100C, mk(32'h800000B7, 64'h100C, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0));
    drive(32'h123450B7, 64'h0000_0000_0000_1010, mk(32'h123450B7, 64'h1010, 64'h0000_0000_1234_5000, 3'd4, 1'b0));
    drive(32'hFFDFF06F, 64'h0000_0000_0000_1014, mk(32'hFFDFF06F, 64'h1014, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0));
    drive(32'h00000000, 64'hDEAD_BEEF_1234_5678, mk(32'h00000000, 64'hDEAD_BEEF_1234_5678, 64'd0, 3'd0, 1'b1));
    drive(32'hFFFFF07F, 64'hCAFE_0000_8765_4320, mk(32'hFFFFF07F, 64'hCAFE_0000_8765_4320, 64'd0, 3'd0, 1'b1));
    drive(32'h002081B3, 64'h0000_0000_0000_2000, mk(32'h002081B3, 64'h2000, 64'd0, 3'd0, 1'b0));
    drive(32'h00100073, 64'h0000_0000_0000_2004, mk(32'h00100073, 64'h2004, 64'd1, 3'd1, 1'b0));
    wait_empty("decode");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(32'h00100093, 64'h0, model(32'h00100093, 64'h0));
    drive(32'h00200113, 64'h4, model(32'h00200113, 64'h4));
    checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: got rdy=%b%b, required 00", rdy32, rdy64);
    end
    fork
      drive(32'h00300193, 64'h8, model(32'h00300193, 64'h8));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (vld32 !== 1'b1) begin
            errors++;
            $display("FAIL bp_consecutive: cycle %0d out_valid=%b, required 1", k, vld32);
          end
        end
      end
    join
    wait_empty("bp");
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    drive(32'h00500293, 64'h40, model(32'h00500293, 64'h40));
    drive(32'h00600313, 64'h44, model(32'h00600313, 64'h44));
    in_valid = 1'b1; instr = 32'h00700393; pc = 64'h48;
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    checks++;
    if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
      errors++;
      $display("FAIL flush_state: got vld=%b%b rdy=%b%b, required vld=00 rdy=11", vld32, vld64, rdy32, rdy64);
    end
    checks++;
    if (pc64 !== 64'h40 || ins32 !== 32'h00500293) begin
      errors++;
      $display("FAIL flush_data_hold: got pc=%h instr=%h, required pc=40 instr=00500293", pc64, ins32);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vld32 !== 1'b0 || vld64 !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_delivery: got vld=%b%b, required 00", vld32, vld64);
    end
  endtask

  task automatic test_reset_midop();
    fill_two();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    q.delete();
    checks++;
    if ({vld32, vld64, rdy32, rdy64} !== 4'b0011) begin
      errors++;
      $display("FAIL midreset_state: got vld=%b%b rdy=%b%b, required vld=00 rdy=11", vld32, vld64, rdy32, rdy64);
    end
    checks++;
    if ({ins32, pc32, imm32, typ32, ill32, ins64, pc64, imm64, typ64, ill64} !== '0) begin
      errors++;
      $display("FAIL midreset_data: got instr=%h pc=%h imm=%h, required all zero", ins64, pc64, imm64);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vld32 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_delivery: got vld=%b, required 0", vld32);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6f, 7'h33, 7'h0f, 7'h73, 7'h7f, 7'h5b};
    bit busy = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [31:0] i;
          logic [63:0] p;
          i = $urandom();
          i[6:0] = ops[$urandom_range(0, 12)];
          if ($urandom_range(0, 7) == 0) i[1:0] = 2'($urandom_range(0, 2));
          p = {$urandom(), $urandom()};
          drive(i, p, model(i, p));
        end
        busy = 1'b0;
      end
      while (busy) begin
        @(posedge clk); #2;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    out_ready = 1'b1;
    wait_empty("random");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
